// File: rtl/tpu_mac_dot_sequencer.sv
// Operand FIFO + dot-product sequencer for the MAC unit; first issue 2 cycles after command, one MAC op in flight.
// op_ready drops when the FIFO is full, dot_valid holds until dot_ready; TPU_DOTSEQ_TIMEOUT_EN adds a WAIT watchdog.
module tpu_mac_dot_sequencer #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [2:0]       cmd_dtype,
  input  logic [31:0]      cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_enable,
  output logic [2:0]       mac_data_type,
  output logic [15:0]      mac_a_data,
  output logic [15:0]      mac_b_data,
  output logic [31:0]      mac_c_data,
  output logic             mac_valid_in,
  input  logic [31:0]      mac_result,
  input  logic             mac_valid_out,
  input  logic             mac_ready,
  output logic             dot_valid,
  input  logic             dot_ready,
  output logic [31:0]      dot_result,
  output logic             dot_err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } op_pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  op_pair_t         fifo_mem [DEPTH];
  op_pair_t         head;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, push, pop;
  logic [31:0]      acc;
  logic [LEN_W-1:0] remaining;
  logic             issue_go, cmd_fire, result_fire, last_elem, timeout_hit;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = op_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  assign cmd_fire    = (state_q == IDLE) && cmd_valid;
  assign issue_go    = (state_q == ISSUE) && !fifo_empty && mac_ready;
  assign pop         = issue_go;
  assign result_fire = (state_q == WAIT) && mac_valid_out;
  assign last_elem   = (remaining == LEN_W'(1));

`ifdef TPU_DOTSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign timeout_hit = (state_q == WAIT) && !mac_valid_out && (wd_cnt == TW'(TIMEOUT - 1));
  assign dot_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (issue_go)
        wd_cnt <= '0;
      else if (state_q == WAIT && !timeout_hit)
        wd_cnt <= wd_cnt + TW'(1);
      if (cmd_fire)
        err_q <= 1'b0;
      else if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign dot_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    dot_valid = 1'b0;
    busy      = (state_q != IDLE);
    op_ready  = !fifo_full;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: if (issue_go) state_d = WAIT;
      WAIT: begin
        if (mac_valid_out)    state_d = last_elem ? DONE : ISSUE;
        else if (timeout_hit) state_d = DONE;
      end
      DONE: begin
        dot_valid = 1'b1;
        if (dot_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= op_pair_t'{a: op_a, b: op_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mac_enable    <= 1'b0;
      mac_valid_in  <= 1'b0;
      mac_data_type <= '0;
      mac_a_data    <= '0;
      mac_b_data    <= '0;
      mac_c_data    <= '0;
      acc           <= '0;
      remaining     <= '0;
    end else begin
      mac_enable   <= 1'b1;
      mac_valid_in <= issue_go;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (cmd_fire) begin
        mac_data_type <= cmd_dtype;
        acc           <= cmd_bias;
        remaining     <= cmd_len;
      end
      if (issue_go) begin
        mac_a_data <= head.a;
        mac_b_data <= head.b;
        mac_c_data <= acc;
      end
      if (result_fire) begin
        acc       <= mac_result;
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  assign dot_result = acc;

endmodule
